disk_dma_controller: RTL and testbench

- Block-copy engine between the hard-disk word store and main data memory; sits directly upstream of the hard disk on its addr/data/write port and on its data_HD read return.
- CPU-side logic loads source, destination, word count and direction, then pulses start.
- Engine moves one word every two cycles and pulses done on completion.
- Used for program/data loading and for saving memory back to disk.

---
 rtl/disk_dma_controller.sv | 202 ++++++++++++++++++++
 tb/tb_disk_dma_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_dma_controller.sv
// disk_dma_controller
//
// Block-copy engine between the hard-disk word store and main data memory.
// The CPU side loads the operands and pulses start. The engine then copies
// one word every two cycles: a READ cycle presents the source address, and a
// WRITE cycle forwards the returned word to the destination with one strobe.
// done pulses for one cycle at the end. Both the disk and the memory register
// their address, so read data arrives the cycle after the address is shown.
//
// Optional feature (macro DISK_DMA_CHECKSUM_EN):
//   defined   - checksum accumulates every transferred word modulo
//               2**DATA_WIDTH. It clears on each accepted start and holds its
//               final value from the DONE cycle until the next start.
//   undefined - checksum is tied to 0 and no adder is built.
//
// Ports:
//   clock       rising-edge clock shared with the disk and memory
//   reset       asynchronous, active-low reset
//   start       one-cycle transfer request, honoured only when idle
//   dir         0 = disk->memory (load), 1 = memory->disk (store)
//   disk_base   first disk word index (low ADDR_WIDTH bits used)
//   mem_base    first memory word index (low ADDR_WIDTH bits used)
//   word_count  words to move (low ADDR_WIDTH+1 bits, clamped to 2**ADDR_WIDTH)
//   hd_addr     disk address          hd_wdata  disk write data
//   hd_write    disk write strobe     hd_rdata  disk read data (1-cycle latency)
//   mem_addr    memory address        mem_wdata memory write data
//   mem_write   memory write strobe   mem_rdata memory read data (1-cycle latency)
//   busy        high from the cycle after an accepted start through DONE
//   done        one-cycle completion pulse
//   checksum    running sum of transferred words (see optional feature)

module disk_dma_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] disk_base,
  input  logic [DATA_WIDTH-1:0] mem_base,
  input  logic [DATA_WIDTH-1:0] word_count,
  output logic [DATA_WIDTH-1:0] hd_addr,
  output logic [DATA_WIDTH-1:0] hd_wdata,
  output logic                  hd_write,
  input  logic [DATA_WIDTH-1:0] hd_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  // Largest transfer: the whole address space, exactly once.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic                  dir_q;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [CNT_W-1:0]      remaining;

  logic [ADDR_WIDTH-1:0] src_next;
  logic [ADDR_WIDTH-1:0] dst_next;
  logic [ADDR_WIDTH-1:0] disk_base_a;
  logic [ADDR_WIDTH-1:0] mem_base_a;
  logic [CNT_W-1:0]      count_in;

  // Counts above the address space would revisit words; cap at one full pass.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] raw);
    return (raw > MAX_CNT) ? MAX_CNT : raw;
  endfunction

  // Addresses are ADDR_WIDTH wide internally; the upper output bits stay 0.
  function automatic logic [DATA_WIDTH-1:0] widen(input logic [ADDR_WIDTH-1:0] a);
    return {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, a};
  endfunction

  assign disk_base_a = disk_base[ADDR_WIDTH-1:0];
  assign mem_base_a  = mem_base[ADDR_WIDTH-1:0];
  assign count_in    = clamp_count(word_count[CNT_W-1:0]);
  assign src_next    = src + ADDR_WIDTH'(1);
  assign dst_next    = dst + ADDR_WIDTH'(1);

  // High operand bits carry no meaning for this engine.
  logic unused_bits;
  assign unused_bits = ^{disk_base[DATA_WIDTH-1:ADDR_WIDTH],
                         mem_base[DATA_WIDTH-1:ADDR_WIDTH],
                         word_count[DATA_WIDTH-1:CNT_W]};

  // The only combinational outputs: the returned source word goes straight
  // to the destination while its strobe is up, and reads as 0 otherwise.
  assign hd_wdata  = hd_write  ? mem_rdata : '0;
  assign mem_wdata = mem_write ? hd_rdata  : '0;

  // Control FSM. Every output is registered, so start never reaches an
  // output combinationally; each address is loaded on the edge entering the
  // cycle that needs it and otherwise holds its last value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      hd_addr   <= '0;
      mem_addr  <= '0;
      hd_write  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q     <= dir;
            src       <= dir ? mem_base_a : disk_base_a;
            dst       <= dir ? disk_base_a : mem_base_a;
            remaining <= count_in;
            busy      <= 1'b1;
            if (count_in != '0) begin
              state <= READ;
              if (dir) mem_addr <= widen(mem_base_a);
              else     hd_addr  <= widen(disk_base_a);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        READ: begin
          // Source word returns next cycle; set up destination and strobe.
          state <= WRITE;
          if (dir_q) begin
            hd_addr  <= widen(dst);
            hd_write <= 1'b1;
          end else begin
            mem_addr  <= widen(dst);
            mem_write <= 1'b1;
          end
        end

        WRITE: begin
          hd_write  <= 1'b0;
          mem_write <= 1'b0;
          src       <= src_next;
          dst       <= dst_next;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= READ;
            if (dir_q) mem_addr <= widen(src_next);
            else       hd_addr  <= widen(src_next);
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DISK_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  // Accumulate the word actually forwarded in each WRITE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (state == IDLE && start) begin
      sum <= '0;
    end else if (state == WRITE) begin
      sum <= sum + (dir_q ? mem_rdata : hd_rdata);
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_disk_dma_controller.sv
// Bench for disk_dma_controller: models the disk and memory as word arrays
// with a registered read address, keeps a transfer-level reference model
// (cycle index within a transfer -> expected outputs), and runs directed
// transfers with hand-computed results.

module tb_disk_dma_controller;

  localparam int DEPTH = 1 << 14;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        dir   = 1'b0;
  logic [31:0] disk_base  = '0;
  logic [31:0] mem_base   = '0;
  logic [31:0] word_count = '0;
  logic [31:0] hd_addr, hd_wdata, hd_rdata, mem_addr, mem_wdata, mem_rdata, checksum;
  logic        hd_write, mem_write, busy, done;

  logic [31:0] disk_arr [0:DEPTH-1];
  logic [31:0] mem_arr  [0:DEPTH-1];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  disk_dma_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .disk_base  (disk_base),
    .mem_base   (mem_base),
    .word_count (word_count),
    .hd_addr    (hd_addr),
    .hd_wdata   (hd_wdata),
    .hd_write   (hd_write),
    .hd_rdata   (hd_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Disk and memory: registered read address, write on the strobe.
  always @(posedge clock) begin
    hd_rdata  <= disk_arr[hd_addr[13:0]];
    mem_rdata <= mem_arr[mem_addr[13:0]];
    if (hd_write)  disk_arr[hd_addr[13:0]] = hd_wdata;
    if (mem_write) mem_arr[mem_addr[13:0]] = mem_wdata;
  end

  // Reference model: a transfer of N words is a sequence of 2N+1 cycles
  // numbered k=1..2N+1 after acceptance: odd k<=2N reads word (k-1)/2, even
  // k writes word k/2-1, k=2N+1 is the completion cycle.
  bit          m_active = 1'b0;
  bit          m_dir    = 1'b0;
  int          m_k = 0, m_n = 0, m_src = 0, m_dst = 0;
  logic [31:0] m_sum = '0;
  logic [31:0] e_hd_last = '0, e_mem_last = '0;

  function automatic logic [31:0] src_word(input int j);
    int a;
    a = (m_src + j) % DEPTH;
    return m_dir ? mem_arr[a] : disk_arr[a];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_k      = 0;
      m_sum    = '0;
    end else if (m_active) begin
      if (m_k % 2 == 0 && m_k <= 2 * m_n) m_sum = m_sum + src_word(m_k / 2 - 1);
      if (m_k == 2 * m_n + 1) begin
        m_active = 1'b0;
        m_k      = 0;
      end else begin
        m_k++;
      end
    end else if (start) begin
      int c;
      m_dir    = dir;
      m_src    = int'(dir ? mem_base[13:0] : disk_base[13:0]);
      m_dst    = int'(dir ? disk_base[13:0] : mem_base[13:0]);
      c        = int'(word_count[14:0]);
      m_n      = (c > DEPTH) ? DEPTH : c;
      m_active = 1'b1;
      m_k      = 1;
      m_sum    = '0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin : compare
    bit          rd, wr;
    int          j;
    logic [31:0] sa, da, e_cks;
    if (!reset) begin
      e_hd_last  = '0;
      e_mem_last = '0;
    end
    rd = m_active && (m_k <= 2 * m_n) && (m_k % 2 == 1);
    wr = m_active && (m_k <= 2 * m_n) && (m_k % 2 == 0);
    j  = rd ? (m_k - 1) / 2 : (m_k / 2 - 1);
    sa = 32'((m_src + j) % DEPTH);
    da = 32'((m_dst + j) % DEPTH);
    if (rd) begin
      if (m_dir) e_mem_last = sa;
      else       e_hd_last  = sa;
    end
    if (wr) begin
      if (m_dir) e_hd_last  = da;
      else       e_mem_last = da;
    end
`ifdef DISK_DMA_CHECKSUM_EN
    e_cks = m_sum;
`else
    e_cks = '0;
`endif
    chk("busy",      32'(busy),      32'(m_active));
    chk("done",      32'(done),      32'(m_active && m_k == 2 * m_n + 1));
    chk("hd_write",  32'(hd_write),  32'(wr && m_dir));
    chk("mem_write", 32'(mem_write), 32'(wr && !m_dir));
    chk("hd_addr",   hd_addr,   e_hd_last);
    chk("mem_addr",  mem_addr,  e_mem_last);
    chk("checksum",  checksum,  e_cks);
    if (wr && m_dir)  chk("hd_wdata",  hd_wdata,  src_word(j));
    if (wr && !m_dir) chk("mem_wdata", mem_wdata, src_word(j));
  end

  // Issue one transfer; return cycles from start assertion to done, strobe
  // cycles, strobes seen in read cycles and busy cycles. rp>0 re-pulses
  // start with different operands in that cycle.
  task automatic run_xfer(input logic d, input logic [31:0] db, input logic [31:0] mb,
                          input logic [31:0] wc, input int rp, input int limit,
                          output int cyc, output int nstb, output int nrd, output int nbusy);
    @(posedge clock); #1;
    dir = d; disk_base = db; mem_base = mb; word_count = wc; start = 1'b1;
    cyc = 0; nstb = 0; nrd = 0; nbusy = 0;
    @(posedge clock); cyc = 1; #1; start = 1'b0;
    @(negedge clock);
    while (!done && cyc < limit) begin
      nbusy += int'(busy);
      nstb  += int'(hd_write) + int'(mem_write);
      if (cyc % 2 == 1) nrd += int'(hd_write) + int'(mem_write);
      @(posedge clock); cyc++;
      #1;
      if (cyc == rp) begin
        start = 1'b1; dir = ~d; disk_base = db + 32'h10; mem_base = mb + 32'h400; word_count = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    nbusy += int'(busy);
    if (!done) chk("timeout_done", 32'(done), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nstb, nrd, nbusy, ndone;
    for (int i = 0; i < DEPTH; i++) begin
      disk_arr[i] = 32'h1000_0000 + 32'(i * 3);
      mem_arr[i]  = 32'h2000_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) disk_arr[16 + i] = 32'(i + 1);
    mem_arr[8] = 32'hAAAA; mem_arr[9] = 32'hBBBB;
    disk_arr[32'h100] = 32'h11; disk_arr[32'h101] = 32'h22; disk_arr[32'h102] = 32'h33;
    for (int i = 0; i < 5; i++) disk_arr[32'h40 + i] = 32'hA0 + 32'(i);
    disk_arr[32'h60] = 32'd5; disk_arr[32'h61] = 32'd7;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_strobes", 32'(hd_write | mem_write), 0);
    chk("rst_hd_addr", hd_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b1;

    // Load 4 words disk[0x10..0x13] -> mem[0x200..0x203]
    run_xfer(1'b0, 32'h10, 32'h200, 32'd4, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t1_latency", cyc, 9);
    chk("t1_strobes", nstb, 4);
    chk("t1_busy_cycles", nbusy, 9);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem_arr[32'h200 + i], 32'(i + 1));
`ifdef DISK_DMA_CHECKSUM_EN
    chk("t1_checksum", checksum, 32'd10);
`else
    chk("t1_checksum", checksum, 32'd0);
`endif

    // Store 2 words mem[8..9] -> disk[0x3FFF], disk[0x0000] (wrap)
    run_xfer(1'b1, 32'h3FFF, 32'h8, 32'd2, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t2_latency", cyc, 5);
    chk("t2_strobes", nstb, 2);
    chk("t2_read_strobes", nrd, 0);
    chk("t2_disk_3fff", disk_arr[16383], 32'hAAAA);
    chk("t2_disk_0000", disk_arr[0], 32'hBBBB);

    // Zero-length transfer
    run_xfer(1'b0, 32'h50, 32'h600, 32'd0, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t3_latency", cyc, 1);
    chk("t3_strobes", nstb, 0);
    chk("t3_busy_cycles", nbusy, 1);
    chk("t3_checksum", checksum, 32'd0);

    // start re-pulsed mid-transfer with different operands is ignored
    run_xfer(1'b0, 32'h100, 32'h300, 32'd3, 3, 100, cyc, nstb, nrd, nbusy);
    chk("t4_latency", cyc, 7);
    chk("t4_strobes", nstb, 3);
    chk("t4_mem_300", mem_arr[32'h300], 32'h11);
    chk("t4_mem_301", mem_arr[32'h301], 32'h22);
    chk("t4_mem_302", mem_arr[32'h302], 32'h33);
    chk("t4_disk_110", disk_arr[32'h110], 32'h1000_0330);
`ifdef DISK_DMA_CHECKSUM_EN
    chk("t4_checksum", checksum, 32'h66);
`endif
    repeat (4) @(posedge clock);

    // Reset during the WRITE cycle of word 2 of 5
    @(posedge clock); #1;
    dir = 1'b0; disk_base = 32'h40; mem_base = 32'h500; word_count = 32'd5; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #2; chk("t5_pre_mem_write", 32'(mem_write), 1);
    #1; reset = 1'b0;
    #1;
    chk("t5_rst_mem_write", 32'(mem_write), 0);
    chk("t5_rst_hd_write", 32'(hd_write), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    @(negedge clock);
    @(posedge clock); #2; reset = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clock);
      ndone += int'(done);
    end
    chk("t5_no_done", ndone, 0);
    chk("t5_mem_500", mem_arr[32'h500], 32'hA0);
    chk("t5_mem_501", mem_arr[32'h501], 32'h2000_0501);
    chk("t5_mem_502", mem_arr[32'h502], 32'h2000_0502);

    // Fresh transfer after reset: store mem[0x500..0x502] -> disk[0x2000..]
    run_xfer(1'b1, 32'h2000, 32'h500, 32'd3, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t6_latency", cyc, 7);
    chk("t6_disk_2000", disk_arr[32'h2000], 32'hA0);
    chk("t6_disk_2001", disk_arr[32'h2001], 32'h2000_0501);
    chk("t6_disk_2002", disk_arr[32'h2002], 32'h2000_0502);
`ifdef DISK_DMA_CHECKSUM_EN
    chk("t6_checksum", checksum, 32'h4000_0AA3);
`endif

    // Back-to-back: second start in the cycle right after done
    run_xfer(1'b0, 32'h60, 32'h800, 32'd2, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t7a_latency", cyc, 5);
    run_xfer(1'b0, 32'h60, 32'h900, 32'd2, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t7b_latency", cyc, 5);
    chk("t7_mem_900", mem_arr[32'h900], 32'd5);
    chk("t7_mem_901", mem_arr[32'h901], 32'd7);
`ifdef DISK_DMA_CHECKSUM_EN
    chk("t7_checksum", checksum, 32'd12);
`endif

    // Only the low 15 bits of word_count matter: 0x0001_0002 moves 2 words
    run_xfer(1'b1, 32'h3000, 32'h40, 32'h0001_0002, -1, 100, cyc, nstb, nrd, nbusy);
    chk("t8_latency", cyc, 5);
    chk("t8_disk_3000", disk_arr[32'h3000], 32'h2000_0040);
    chk("t8_disk_3001", disk_arr[32'h3001], 32'h2000_0041);

    // Count above the address space clamps to 16384 words
    run_xfer(1'b0, 32'h123, 32'h0, 32'h0000_7FFF, -1, 40000, cyc, nstb, nrd, nbusy);
    chk("t9_latency", cyc, 32769);
    chk("t9_strobes", nstb, 16384);
    chk("t9_mem_0000", mem_arr[0], 32'h1000_0369);
    chk("t9_mem_3fff", mem_arr[16383], 32'h1000_0366);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
